// File: rtl/simple_dp_ram_clr_pkg.sv
// Shared definitions for the clearable simple dual-port RAM:
// FSM state encoding and the read/write collision mode selectors.
package simple_dp_ram_clr_pkg;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_e;

   localparam int COLLISION_READ_FIRST  = 0;
   localparam int COLLISION_WRITE_FIRST = 1;

endpackage

// File: rtl/simple_dp_ram_clr.sv
// Simple dual-port RAM (one write port, one registered read port) with a
// hardware fill sequence that writes FILL to every entry after reset or on clear.
module simple_dp_ram_clr
   import simple_dp_ram_clr_pkg::*;
#(
   parameter int              SIZE           = 8,
   parameter int              DEPTH          = 16,
   parameter int              COLLISION      = COLLISION_READ_FIRST,
   parameter int              CLEAR_ON_RESET = 1,
   parameter logic [SIZE-1:0] FILL           = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [SIZE-1:0]          write_data,
   input  logic                     write_en,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   input  logic                     read_en,
   output logic [SIZE-1:0]          read_data,
   output logic                     read_valid,
   input  logic                     clear,
   output logic                     busy
);

   localparam int             AW        = $clog2(DEPTH);
   localparam logic [AW:0]    DEPTH_C   = (AW+1)'(DEPTH);
   localparam logic [AW-1:0]  LAST_C    = AW'(DEPTH - 1);
   localparam state_e         RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

   state_e          state_q;
   logic [AW-1:0]   cnt_q;
   logic [SIZE-1:0] rdata_q;
   logic            rvalid_q;
   logic [SIZE-1:0] mem_q [DEPTH];

   logic            wr_in_range;
   logic            rd_in_range;
   logic            user_wr;
   logic            mem_we;
   logic [AW-1:0]   mem_waddr;
   logic [SIZE-1:0] mem_wdata;
   logic [SIZE-1:0] rdata_d;

   always_comb begin
      wr_in_range = ({1'b0, waddr} < DEPTH_C);
      rd_in_range = ({1'b0, raddr} < DEPTH_C);
      user_wr     = (state_q == ST_READY) && write_en && wr_in_range;
      // The fill owns the write port while clearing; reset blocks all writes.
      mem_we      = !rst && ((state_q == ST_CLEAR) || user_wr);
      mem_waddr   = (state_q == ST_CLEAR) ? cnt_q : waddr;
      mem_wdata   = (state_q == ST_CLEAR) ? FILL  : write_data;

      rdata_d = mem_q[raddr];
      if (!rd_in_range) begin
         rdata_d = FILL;
      end else if ((COLLISION == COLLISION_WRITE_FIRST) && user_wr && (waddr == raddr)) begin
         rdata_d = write_data;
      end
   end

   // No reset on the array so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= RST_STATE;
         cnt_q    <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         rvalid_q <= 1'b0;
         case (state_q)
            ST_CLEAR: begin
               if (cnt_q == LAST_C) begin
                  cnt_q   <= '0;
                  state_q <= ST_READY;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               if (read_en) begin
                  rdata_q  <= rdata_d;
                  rvalid_q <= 1'b1;
               end
               if (clear) begin
                  state_q <= ST_CLEAR;
                  cnt_q   <= '0;
               end
            end
         endcase
      end
   end

   assign read_data  = rdata_q;
   assign read_valid = rvalid_q;
   assign busy       = (state_q == ST_CLEAR);

endmodule

// File: doc/simple_dp_ram_clr.md
SIMPLE_DP_RAM_CLR -- requirements
Module: simple_dp_ram_clr

Interface
REQ-001 Parameter SIZE, default 8: word width in bits, SIZE >= 1.
REQ-002 Parameter DEPTH, default 16: number of entries, DEPTH >= 2, need not be a power of two.
REQ-003 Parameter COLLISION, default 0: 0 = read-first (old data), 1 = write-first (new data) on same-address read/write.
REQ-004 Parameter CLEAR_ON_RESET, default 1: 1 = memory fill sequence starts automatically after reset.
REQ-005 Parameter FILL, default 0 (SIZE bits): value written by the clear sequence.
REQ-006 Port clk, input, 1: the only clock; all logic is on its rising edge.
REQ-007 Port rst, input, 1: reset, synchronous and active-high.
REQ-008 Port waddr, input, $clog2(DEPTH): write address.
REQ-009 Port write_data, input, SIZE: data to write.
REQ-010 Port write_en, input, 1: 1 = write write_data to waddr this cycle.
REQ-011 Port raddr, input, $clog2(DEPTH): read address.
REQ-012 Port read_en, input, 1: 1 = read raddr this cycle.
REQ-013 Port read_data, output, SIZE: registered read result.
REQ-014 Port read_valid, output, 1: 1 = read_data carries the result of the previous cycle's accepted read.
REQ-015 Port clear, input, 1: 1 in READY = start the fill sequence.
REQ-016 Port busy, output, 1: 1 while the fill sequence runs; user accesses are ignored.

Function
REQ-017 FSM states SHALL be CLEAR and READY.
REQ-018 In CLEAR, one entry per cycle SHALL be written with FILL at counter addresses 0..DEPTH-1; after address DEPTH-1 the FSM SHALL enter READY with the counter reset to 0 (DEPTH cycles total).
REQ-019 READY SHALL go to CLEAR when clear=1; clear SHALL be ignored while in CLEAR.
REQ-020 busy SHALL be 1 exactly when the state is CLEAR.
REQ-021 In CLEAR, write_en and read_en SHALL be ignored: no user write; read_valid=0; read_data held.
REQ-022 In READY, write_en=1 with waddr < DEPTH SHALL update that entry at the clock edge.
REQ-023 Writes with waddr >= DEPTH SHALL be dropped.
REQ-024 A read accepted in READY (read_en=1) at cycle N SHALL present read_data at N+1 with read_valid=1 for one cycle. read_en=0 SHALL give read_valid=0 with read_data held.
REQ-025 Reads with raddr >= DEPTH SHALL return FILL with read_valid=1.
REQ-026 Same-cycle write and read of one address SHALL return the pre-write value if COLLISION=0, or write_data if COLLISION=1.
REQ-027 Back-to-back reads SHALL sustain one result per cycle with no bubbles.

Reset
REQ-028 While rst=1: read_data=0, read_valid=0, fill counter=0, no memory write.
REQ-029 The cycle after rst deasserts, the state SHALL be CLEAR (busy=1) if CLEAR_ON_RESET=1, else READY (busy=0).
REQ-030 rst during CLEAR SHALL abort the fill; a re-entered fill restarts at address 0.
REQ-031 Memory contents SHALL NOT be reset directly; only the fill sequence changes them.

Structure
REQ-032 The state encoding and the COLLISION mode constants SHALL live in the shared package.
REQ-033 The block SHALL be one module with an inferred memory array and no sub-module, so synthesis maps large instances to block RAM.

Verification
REQ-034 Bench SHALL cover reset with CLEAR_ON_RESET=1, DEPTH=16, FILL=8'hA5 -> busy=1 for exactly 16 cycles; then reads of addresses 0..15 all return 8'hA5 with read_valid=1.
REQ-035 Bench SHALL cover: write 8'h3C to address 5, then read 5 the next cycle -> read_data=8'h3C one cycle after read_en, read_valid pulse 1 cycle.
REQ-036 Bench SHALL cover: address 7 holds 8'h11; same cycle write 8'h22 and read 7 -> 8'h11 (COLLISION=0) or 8'h22 (COLLISION=1); next read -> 8'h22.
REQ-037 Bench SHALL cover DEPTH=10: write 8'hFF to address 12, then read 12 -> FILL returned; address 2 (12 mod 10) unchanged.
REQ-038 Bench SHALL cover: assert clear, then rst on the 5th busy cycle -> after reset, busy=1 for a full 16 cycles and all entries = FILL.
REQ-039 Bench SHALL cover: write_en and read_en asserted during CLEAR -> read_valid=0 throughout and no target entry differs from FILL afterwards.
